// File: rtl/sort4_scheduler.sv
// sort4_scheduler: loads an N-sample frame, bubble-sorts it with one shared
// compare unit, then drains it ascending over a valid/ready stream.
module sort4_scheduler #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       busy
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [W-1:0] wr_idx, rd_idx, j, pass, jn;
  logic [3:0] mem [N];
  logic [3:0] a, b, lo, hi;
  logic swap;
  // The only comparator: orders the pair at j; equal values take the no-swap path.
  always_comb begin
    jn = j + W'(1);
    a = mem[j];
    b = mem[jn];
    swap = b < a;
    lo = swap ? b : a;
    hi = swap ? a : b;
  end
  assign in_ready  = !rst && state == LOAD;
  assign out_valid = !rst && state == DRAIN;
  assign busy      = !rst && state != LOAD;
  assign out_data  = out_valid ? mem[rd_idx] : 4'd0;
  assign out_last  = out_valid && rd_idx == W'(N - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      j <= '0;
      pass <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (state == LOAD) begin
      if (in_valid) begin
        mem[wr_idx] <= in_data;
        wr_idx <= (wr_idx == W'(N - 1)) ? '0 : wr_idx + W'(1);
        if (wr_idx == W'(N - 1)) begin
          state <= SORT;
          j <= '0;
          pass <= '0;
        end
      end
    end else if (state == SORT) begin
      mem[j] <= lo;
      mem[jn] <= hi;
      j <= (j == W'(N - 2)) ? '0 : jn;
      if (j == W'(N - 2)) begin
        pass <= pass + W'(1);
        if (pass == W'(N - 2)) begin
          state <= DRAIN;
          rd_idx <= '0;
        end
      end
    end else if (state == DRAIN) begin
      if (out_ready) begin
        rd_idx <= out_last ? '0 : rd_idx + W'(1);
        if (out_last) state <= LOAD;
      end
    end else begin
      state <= LOAD;
    end
  end
endmodule

// File: tb/tb_sort4_scheduler.sv
// tb_sort4_scheduler: scenario tasks driving frames and checking against a
// counting-sort reference, latency/throughput arithmetic and handshake rules.
module tb_sort4_scheduler;
  typedef logic [3:0] frame_t [4];
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, out_last, busy;
  logic [3:0] out_data;
  int errs = 0, checks = 0, cyc = 0;

  sort4_scheduler #(.N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic frame_t sort_ref(input frame_t d);
    frame_t s;
    int cnt [16];
    int k = 0;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < 4; i++) cnt[d[i]]++;
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < cnt[v]; c++) begin
        s[k] = 4'(v);
        k++;
      end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds one frame; t_acc is the cycle number of the final accept.
  task automatic load_frame(input frame_t d, input bit gaps, output int t_acc);
    int k = 0;
    t_acc = 0;
    for (int g = 0; g < 200 && k < 4; g++) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = in_valid ? d[k] : 4'($urandom);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL load_flags: in_ready=%b busy=%b, required 1/0", in_ready, busy);
      end
      if (in_valid && in_ready) begin
        k++;
        if (k == 4) t_acc = cyc;
      end
      step();
    end
    checks++;
    if (k != 4) begin
      errs++;
      $display("FAIL load_timeout: accepted %0d samples, required 4", k);
    end
  endtask

  // Waits through SORT and DRAIN; mode 0 ready always, 1 stall-then-toggle, 2 random.
  task automatic drain_frame(input frame_t exp, input int t_acc, input int mode);
    int n = 0, vc = 0;
    bit first = 1, hs;
    for (int g = 0; g < 200 && n < 4; g++) begin
      in_valid = 1;
      in_data = 4'd5;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (vc >= 5 && vc[0]) : 1'($urandom_range(0, 1));
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL busy_flags: busy=%b in_ready=%b, required 1/0", busy, in_ready);
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== 4'd0 || out_last !== 1'b0) begin
          errs++;
          $display("FAIL idle_out: data=%0d last=%b, required 0/0", out_data, out_last);
        end
      end else begin
        vc++;
        if (first) begin
          first = 0;
          checks++;
          if (cyc - t_acc != 10) begin
            errs++;
            $display("FAIL latency: %0d cycles, required 10", cyc - t_acc);
          end
        end
        checks++;
        if (out_data !== exp[n] || out_last !== (n == 3)) begin
          errs++;
          $display("FAIL out_%0d: data=%0d last=%b, required %0d/%b", n, out_data, out_last, exp[n], n == 3);
        end
      end
      hs = out_valid && out_ready;
      step();
      if (hs) n++;
    end
    in_valid = 0;
    out_ready = 0;
    checks++;
    if (n != 4) begin
      errs++;
      $display("FAIL drain_timeout: %0d outputs, required 4", n);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL back_to_load: busy=%b in_ready=%b out_valid=%b, required 0/1/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic run_frame(input frame_t d, input bit gaps, input int mode);
    int t;
    load_frame(d, gaps, t);
    drain_frame(sort_ref(d), t, mode);
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 0 || out_valid !== 0 || out_data !== 0 || out_last !== 0 || busy !== 0) begin
        errs++;
        $display("FAIL reset_outs: rdy=%b v=%b d=%0d l=%b b=%b, required all 0", in_ready, out_valid, out_data, out_last, busy);
      end
      step();
    end
    rst = 0;
    in_valid = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_frame('{4'd9, 4'd3, 4'd12, 4'd3}, 0, 0);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    load_frame('{4'd15, 4'd8, 4'd4, 4'd0}, 0, t1);
    drain_frame('{4'd0, 4'd4, 4'd8, 4'd15}, t1, 0);
    load_frame('{4'd0, 4'd1, 4'd2, 4'd15}, 0, t2);
    drain_frame('{4'd0, 4'd1, 4'd2, 4'd15}, t2, 0);
    checks++;
    if (t2 - t1 != 17) begin
      errs++;
      $display("FAIL throughput: period %0d cycles, required 17", t2 - t1);
    end
  endtask

  task automatic test_equal();
    run_frame('{4'd7, 4'd7, 4'd7, 4'd7}, 0, 0);
  endtask

  task automatic test_stall();
    frame_t d;
    for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
    run_frame(d, 0, 1);
  endtask

  task automatic test_in_gaps();
    run_frame('{4'd11, 4'd2, 4'd14, 4'd6}, 1, 0);
  endtask

  task automatic test_reset_abort();
    int t;
    load_frame('{4'd13, 4'd10, 4'd9, 4'd1}, 0, t);
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    rst = 1;
    #0;
    checks++;
    if (in_ready !== 0 || out_valid !== 0 || busy !== 0) begin
      errs++;
      $display("FAIL abort_rst: rdy=%b v=%b b=%b, required 0/0/0", in_ready, out_valid, busy);
    end
    step();
    rst = 0;
    for (int i = 0; i < 15; i++) begin
      #0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL abort_idle: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
      step();
    end
    run_frame('{4'd2, 4'd1, 4'd0, 4'd3}, 0, 0);
  endtask

  task automatic test_random();
    frame_t d;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 15));
      run_frame(d, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_equal();
    test_stall();
    test_in_gaps();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
